// File: rtl/adc_sample_sequencer_if.sv
// adc_sample_sequencer_if: Avalon-MM register bus, ADC conversion handshake and interrupt line of the sequencer.
interface adc_sample_sequencer_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        adc_start;
    logic [2:0]  adc_ch;
    logic        adc_done;
    logic [15:0] adc_data;
    logic        irq;

    modport slave (
        input  address, chipselect, write_n, writedata, adc_done, adc_data,
        output readdata, adc_start, adc_ch, irq
    );

    modport master (
        output address, chipselect, write_n, writedata, adc_done, adc_data,
        input  readdata, adc_start, adc_ch, irq
    );
endinterface

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: Avalon-MM controlled ADC channel-mask scanner with per-channel result registers.
// Optional ADC_SEQ_AVERAGE_EN: four back-to-back conversions per channel, result is the 18-bit sum / 4.
module adc_sample_sequencer #(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input logic                   clk,
    input logic                   reset_n,
    adc_sample_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] NEXT  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] STORE = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        lmask_q, lmask_d;
    logic [7:0]        mask_q, mask_d;
    logic              run_q, run_d;
    logic [15:0]       period_q, period_d;
    logic [2:0]        status_q, status_d;
    logic [2:0]        irq_mask_q, irq_mask_d;
    logic [DATA_W-1:0] result_q [NUM_CH];
    logic [DATA_W-1:0] result_d [NUM_CH];
    logic [NUM_CH-1:0] new_q, new_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [DATA_W-1:0] store_val;

`ifdef ADC_SEQ_AVERAGE_EN
    logic [DATA_W+1:0] sum_q, sum_d;
    logic [1:0]        rep_q, rep_d;
    assign store_val = sum_q[DATA_W+1:2];
`else
    logic [DATA_W-1:0] data_q, data_d;
    assign store_val = data_q;
`endif

    logic        wr, wr_ctrl, trig, run_eff, rd_res, hit;
    logic [7:0]  mask_eff;
    logic [2:0]  st_set, st_clr;
    logic [3:0]  nxt, from_idx;
    logic [31:0] res_rd;

    // A CTRL write takes effect in the same cycle, so mask+trigger can be issued in one write.
    assign wr       = bus.chipselect && !bus.write_n;
    assign wr_ctrl  = wr && bus.address == 4'd0;
    assign trig     = wr_ctrl && bus.writedata[1];
    assign run_eff  = wr_ctrl ? bus.writedata[0] : run_q;
    assign mask_eff = wr_ctrl ? bus.writedata[15:8] : mask_q;
    assign st_clr   = (wr && bus.address == 4'd2) ? bus.writedata[2:0] : 3'b0;
    assign rd_res   = bus.chipselect && bus.write_n && bus.address[3];
    assign from_idx = idx_q + 4'd1;

    // Index -1 is 4'hF, so the upward search from it wraps to channel 0.
    always_comb begin
        hit = 1'b0;
        nxt = 4'd0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (lmask_q[i] && 4'(i) >= from_idx) begin
                hit = 1'b1;
                nxt = 4'(i);
            end
    end

    always_comb begin
        res_rd = 32'd0;
        for (int i = 0; i < NUM_CH; i++)
            if (bus.address[2:0] == 3'(i)) res_rd = {new_q[i], 15'd0, 16'(result_q[i])};
        readdata_d = bus.address == 4'd0 ? {16'd0, mask_q, 7'd0, run_q} :
                     bus.address == 4'd1 ? {16'd0, period_q} :
                     bus.address == 4'd2 ? {28'd0, state_q != IDLE, status_q} :
                     bus.address == 4'd3 ? {29'd0, irq_mask_q} :
                     bus.address[3]      ? res_rd : 32'd0;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        lmask_d    = lmask_q;
        run_d      = run_eff;
        mask_d     = mask_eff;
        period_d   = (wr && bus.address == 4'd1) ? bus.writedata[15:0] : period_q;
        irq_mask_d = (wr && bus.address == 4'd3) ? bus.writedata[2:0] : irq_mask_q;
        result_d   = result_q;
        new_d      = new_q;
        st_set     = 3'b0;
`ifdef ADC_SEQ_AVERAGE_EN
        sum_d      = sum_q;
        rep_d      = rep_q;
`else
        data_d     = data_q;
`endif
        for (int i = 0; i < NUM_CH; i++)
            if (rd_res && bus.address[2:0] == 3'(i)) new_d[i] = 1'b0;
        case (state_q)
            IDLE:
                if ((run_eff || trig) && mask_eff[NUM_CH-1:0] != '0) begin
                    lmask_d = mask_eff;
                    idx_d   = 4'hF;
                    state_d = NEXT;
                end
            NEXT:
                if (hit) begin
                    idx_d   = nxt;
                    state_d = START;
`ifdef ADC_SEQ_AVERAGE_EN
                    sum_d   = '0;
                    rep_d   = 2'd0;
`endif
                end else begin
                    st_set[0] = 1'b1;
                    cnt_d     = period_q;
                    state_d   = run_q ? GAP : IDLE;
                end
            START: begin
                cnt_d   = 16'd0;
                state_d = WAIT;
            end
            WAIT:
                if (bus.adc_done) begin
`ifdef ADC_SEQ_AVERAGE_EN
                    sum_d   = sum_q + {2'b00, bus.adc_data};
                    rep_d   = rep_q + 2'd1;
                    state_d = rep_q == 2'd3 ? STORE : START;
`else
                    data_d  = bus.adc_data;
                    state_d = STORE;
`endif
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    st_set[2] = 1'b1;
                    state_d   = NEXT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            STORE: begin
                // A read clearing the old flag in this same cycle consumed that value: no overrun.
                for (int i = 0; i < NUM_CH; i++)
                    if (idx_q == 4'(i)) begin
                        result_d[i] = store_val;
                        new_d[i]    = 1'b1;
                        st_set[1]   = new_q[i] && !(rd_res && bus.address[2:0] == 3'(i));
                    end
                state_d = NEXT;
            end
            GAP: begin
                cnt_d   = cnt_q - 16'd1;
                state_d = cnt_q == 16'd0 ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
        status_d = (status_q & ~st_clr) | st_set;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            cnt_q      <= 16'd0;
            lmask_q    <= 8'd0;
            mask_q     <= 8'd0;
            run_q      <= 1'b0;
            period_q   <= 16'd0;
            status_q   <= 3'd0;
            irq_mask_q <= 3'd0;
            result_q   <= '{default: '0};
            new_q      <= '0;
            readdata_q <= 32'd0;
`ifdef ADC_SEQ_AVERAGE_EN
            sum_q      <= '0;
            rep_q      <= 2'd0;
`else
            data_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            lmask_q    <= lmask_d;
            mask_q     <= mask_d;
            run_q      <= run_d;
            period_q   <= period_d;
            status_q   <= status_d;
            irq_mask_q <= irq_mask_d;
            result_q   <= result_d;
            new_q      <= new_d;
            readdata_q <= readdata_d;
`ifdef ADC_SEQ_AVERAGE_EN
            sum_q      <= sum_d;
            rep_q      <= rep_d;
`else
            data_q     <= data_d;
`endif
        end

    assign bus.readdata  = readdata_q;
    assign bus.adc_start = state_q == START;
    assign bus.adc_ch    = idx_q[2:0];
    assign bus.irq       = |(status_q & irq_mask_q);
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: directed self-checking bench for adc_sample_sequencer (default and ADC_SEQ_AVERAGE_EN builds).
module tb_adc_sample_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    adc_sample_sequencer_if bus();
    adc_sample_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

`ifdef ADC_SEQ_AVERAGE_EN
    localparam int REPS = 4;
    localparam int OFF  = 1;
`else
    localparam int REPS = 1;
    localparam int OFF  = 0;
`endif

    int errors = 0;
    int checks = 0;
    int nstarts = 0;
    logic [2:0] chlog [0:255];
    time tlog [0:255];
    logic resp_en = 1'b0;
    int resp_delay = 10;
    logic [15:0] resp_data [8];
    int stray_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (bus.adc_start === 1'b1) begin
            if (nstarts < 256) begin
                chlog[nstarts] = bus.adc_ch;
                tlog[nstarts] = $time;
            end
            nstarts++;
        end
    end

    // ADC model: answers each start after resp_delay negedges; averaging build adds 0..3 per repeat.
    initial begin
        int stray_seen;
        int avg_k;
        stray_seen = 0;
        avg_k = 0;
        bus.adc_done = 1'b0;
        bus.adc_data = 16'd0;
        forever begin
            @(negedge clk);
            bus.adc_done = 1'b0;
            if (stray_cnt != stray_seen) begin
                stray_seen++;
                bus.adc_done = 1'b1;
                bus.adc_data = 16'hDEAD;
            end else if (resp_en && bus.adc_start === 1'b1) begin
                logic [2:0] ch;
                ch = bus.adc_ch;
                repeat (resp_delay) @(negedge clk);
                bus.adc_done = 1'b1;
`ifdef ADC_SEQ_AVERAGE_EN
                bus.adc_data = resp_data[ch] + 16'(avg_k % 4);
                avg_k++;
`else
                bus.adc_data = resp_data[ch];
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang want finish");
        $fatal(1);
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
        @(posedge clk); #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        logic [31:0] d;
        int n;
        d = 32'h8;
        n = 0;
        while (d[3] && n < 1500) begin
            rd(4'd2, d);
            n++;
        end
        checks++;
        if (d[3] !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy got %b want 0 after %0d reads", nm, d[3], n);
        end
    endtask

    // Returns at negedge+1 of the cycle in which adc_start was first seen.
    task automatic wait_start(input int s, input string nm);
        int n;
        n = 0;
        while (nstarts == s && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (nstarts == s) begin
            errors++;
            $display("FAIL %s_start: adc_start count got %0d want >%0d", nm, nstarts, s);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.adc_start, bus.adc_ch, bus.irq, bus.readdata} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: got start=%b ch=%0d irq=%b rd=%h want all 0",
                     bus.adc_start, bus.adc_ch, bus.irq, bus.readdata);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int a = 0; a < 16; a += 3) begin
            rd(4'(a), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h want 00000000", a, d);
            end
        end
        wr(4'd1, 32'h1234_5678);
        rd(4'd1, d);
        checks++;
        if (d !== 32'h0000_5678) begin
            errors++;
            $display("FAIL period_width: got %h want 00005678", d);
        end
        wr(4'd3, 32'hFFFF_FFFF);
        rd(4'd3, d);
        checks++;
        if (d !== 32'h0000_0007) begin
            errors++;
            $display("FAIL irq_mask_width: got %h want 00000007", d);
        end
        wr(4'd5, 32'hFFFF_FFFF);
        rd(4'd5, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL unmapped: got %h want 00000000", d);
        end
        wr(4'd3, 32'd0);
    endtask

`ifdef ADC_SEQ_AVERAGE_EN
    task automatic test_average;
        logic [31:0] d;
        int s;
        resp_en = 1'b1;
        resp_delay = 3;
        resp_data[0] = 16'd100;
        s = nstarts;
        wr(4'd0, 32'h0000_0102);
        wait_idle("average");
        checks++;
        if (nstarts - s !== 4) begin
            errors++;
            $display("FAIL average_starts: got %0d want 4", nstarts - s);
        end
        rd(4'd8, d);
        checks++;
        if (d !== 32'h8000_0065) begin
            errors++;
            $display("FAIL average_result: got %h want 80000065", d);
        end
        wr(4'd2, 32'h7);
    endtask
`endif

    task automatic test_single;
        logic [31:0] d;
        int s;
        wr(4'd3, 32'h1);
        resp_en = 1'b1;
        resp_delay = 10;
        resp_data[0] = 16'h1234;
        resp_data[2] = 16'hABCD;
        s = nstarts;
        wr(4'd0, 32'h0000_0502);
        wait_idle("single");
        checks++;
        if (nstarts - s !== 2 * REPS) begin
            errors++;
            $display("FAIL single_starts: got %0d want %0d", nstarts - s, 2 * REPS);
        end
        checks++;
        if (chlog[s] !== 3'd0 || chlog[s + REPS] !== 3'd2) begin
            errors++;
            $display("FAIL single_channels: got %0d,%0d want 0,2", chlog[s], chlog[s + REPS]);
        end
        rd(4'd8, d);
        checks++;
        if (d !== 32'h8000_1234 + OFF) begin
            errors++;
            $display("FAIL single_result0: got %h want %h", d, 32'h8000_1234 + OFF);
        end
        rd(4'd10, d);
        checks++;
        if (d !== 32'h8000_ABCD + OFF) begin
            errors++;
            $display("FAIL single_result2: got %h want %h", d, 32'h8000_ABCD + OFF);
        end
        rd(4'd8, d);
        checks++;
        if (d !== 32'h0000_1234 + OFF) begin
            errors++;
            $display("FAIL new_flag_clear: got %h want %h", d, 32'h0000_1234 + OFF);
        end
        rd(4'd2, d);
        checks++;
        if (d !== 32'h1 || bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL single_status_irq: got status=%h irq=%b want 00000001 irq=1", d, bus.irq);
        end
        wr(4'd2, 32'h1);
        rd(4'd2, d);
        checks++;
        if (d !== 32'h0 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL status_w1c: got status=%h irq=%b want 00000000 irq=0", d, bus.irq);
        end
    endtask

    task automatic test_continuous;
        logic [31:0] d;
        int s;
        int n;
        resp_en = 1'b1;
        resp_delay = 10;
        resp_data[0] = 16'h0055;
        wr(4'd1, 32'd100);
        s = nstarts;
        wr(4'd0, 32'h0000_0101);
        n = 0;
        while (nstarts < s + REPS + 1 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        rd(4'd2, d);
        checks++;
        if (d[1] !== 1'b0 || d[0] !== 1'b1) begin
            errors++;
            $display("FAIL cont_first_pass: got status=%h want pass_done=1 overrun=0", d);
        end
        n = 0;
        while (nstarts < s + 2 * REPS + 1 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        rd(4'd2, d);
        checks++;
        if (d[2:0] !== 3'b011) begin
            errors++;
            $display("FAIL cont_overrun: got status=%h want [2:0]=011", d);
        end
        checks++;
        if (tlog[s + REPS] - tlog[s] !== time'((116 + (REPS - 1) * 11) * 10) ||
            tlog[s + 2 * REPS] - tlog[s + REPS] !== time'((116 + (REPS - 1) * 11) * 10)) begin
            errors++;
            $display("FAIL cont_period: got %0t,%0t want %0d ns", tlog[s + REPS] - tlog[s],
                     tlog[s + 2 * REPS] - tlog[s + REPS], (116 + (REPS - 1) * 11) * 10);
        end
        wr(4'd0, 32'h0000_0100);
        wait_idle("cont_stop");
        rd(4'd8, d);
        checks++;
        if (d !== 32'h8000_0055 + OFF) begin
            errors++;
            $display("FAIL cont_result0: got %h want %h", d, 32'h8000_0055 + OFF);
        end
        wr(4'd2, 32'h7);
    endtask

    task automatic test_mask_zero;
        logic [31:0] d;
        int s;
        s = nstarts;
        wr(4'd0, 32'h0000_0003);
        repeat (20) @(posedge clk);
        rd(4'd2, d);
        checks++;
        if (d !== 32'd0 || nstarts !== s) begin
            errors++;
            $display("FAIL mask_zero: got status=%h starts=%0d want 00000000 starts=0", d, nstarts - s);
        end
        rd(4'd0, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL ctrl_trigger_reads0: got %h want 00000001", d);
        end
        wr(4'd0, 32'd0);
    endtask

    task automatic test_timeout;
        logic [31:0] d;
        int s;
        int n;
        resp_en = 1'b0;
        wr(4'd3, 32'h4);
        s = nstarts;
        wr(4'd0, 32'h0000_0202);
        wait_start(s, "timeout");
        n = 0;
        while (bus.irq !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 1020 || n > 1026) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles want 1020..1026", n);
        end
        wait_idle("timeout");
        rd(4'd2, d);
        checks++;
        if (d !== 32'h5) begin
            errors++;
            $display("FAIL timeout_status: got %h want 00000005", d);
        end
        rd(4'd9, d);
        checks++;
        if (d !== 32'd0 || nstarts - s !== 1) begin
            errors++;
            $display("FAIL timeout_result1: got %h starts=%0d want 00000000 starts=1", d, nstarts - s);
        end
        wr(4'd2, 32'h7);
        wr(4'd3, 32'h0);
    endtask

    task automatic test_status_race;
        logic [31:0] d;
        int s;
        resp_en = 1'b1;
        resp_delay = 10;
        resp_data[0] = 16'h0042;
        s = nstarts;
        wr(4'd0, 32'h0000_0102);
        wait_start(s, "status_race");
        repeat (REPS * 11 + 1) @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 4'd2; bus.writedata = 32'h1;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        wait_idle("status_race");
        rd(4'd2, d);
        checks++;
        if (d[0] !== 1'b1) begin
            errors++;
            $display("FAIL status_race_set_wins: got pass_done=%b want 1", d[0]);
        end
        wr(4'd2, 32'h1);
        rd(4'd2, d);
        checks++;
        if (d[0] !== 1'b0) begin
            errors++;
            $display("FAIL status_race_clear: got pass_done=%b want 0", d[0]);
        end
    endtask

    task automatic test_store_read_race;
        logic [31:0] d;
        int s;
        wr(4'd2, 32'h7);
        resp_data[0] = 16'h0077;
        s = nstarts;
        wr(4'd0, 32'h0000_0102);
        wait_start(s, "store_race");
        repeat (REPS * 11) @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = 4'd8;
        @(negedge clk);
        d = bus.readdata;
        bus.chipselect = 1'b0;
        checks++;
        if (d !== 32'h8000_0042 + OFF) begin
            errors++;
            $display("FAIL store_race_old: got %h want %h", d, 32'h8000_0042 + OFF);
        end
        wait_idle("store_race");
        rd(4'd8, d);
        checks++;
        if (d !== 32'h8000_0077 + OFF) begin
            errors++;
            $display("FAIL store_race_new: got %h want %h", d, 32'h8000_0077 + OFF);
        end
        rd(4'd2, d);
        checks++;
        if (d[1] !== 1'b0) begin
            errors++;
            $display("FAIL store_race_overrun: got %b want 0", d[1]);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] d;
        int s;
        resp_en = 1'b0;
        wr(4'd3, 32'h1);
        wr(4'd1, 32'd77);
        s = nstarts;
        wr(4'd0, 32'h0000_0802);
        wait_start(s, "reset_wait");
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.adc_start, bus.adc_ch, bus.irq, bus.readdata} !== 37'd0) begin
            errors++;
            $display("FAIL reset_async: got start=%b ch=%0d irq=%b rd=%h want all 0",
                     bus.adc_start, bus.adc_ch, bus.irq, bus.readdata);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        stray_cnt++;
        repeat (5) @(posedge clk);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL reset_wait_reg%0d: got %h want 00000000", a, d);
            end
        end
        checks++;
        if (nstarts !== s + 1) begin
            errors++;
            $display("FAIL reset_wait_starts: got %0d want 1", nstarts - s);
        end
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.address = 4'd0;
        bus.writedata = 32'd0;
        for (int i = 0; i < 8; i++) resp_data[i] = 16'd0;
        test_reset;
`ifdef ADC_SEQ_AVERAGE_EN
        test_average;
`endif
        test_single;
        test_continuous;
        test_mask_zero;
        test_timeout;
        test_status_race;
        test_store_read_race;
        test_reset_mid_wait;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
